rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles one grant may be held (used only when ARB_TIMEOUT_EN is defined).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port EN, input, 1, arbitration enable; new grants are issued only when EN=1.
REQ-005 SHALL have port REQ, input, 4, one request line per requester, bit i = requester i.
REQ-006 SHALL have port DONE, input, 1, the current grant holder releases the resource.
REQ-007 SHALL have port GNT, output, 4, registered one-hot grant, all-zero when no grant is active.
REQ-008 SHALL have port GNT_IDX, output, 2, binary index of the current or most recent grant holder.
REQ-009 SHALL have port BUSY, output, 1, high while in state GRANT.
REQ-010 SHALL have port TOUT, output, 1, one-cycle timeout pulse (constant 0 when ARB_TIMEOUT_EN is undefined).

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-012 In IDLE or RELEASE with EN=1 and REQ!=0: at the next edge SHALL go to GRANT, latch the winner into GNT_IDX, and drive GNT to its one-hot code.
REQ-013 Winner SHALL be the first asserted REQ bit searching upward from (last holder + 1) mod 4, wrapping 3->0.
REQ-014 Request-to-grant latency SHALL be exactly 1 cycle from a qualifying IDLE or RELEASE cycle.
REQ-015 In GRANT, DONE=1 or REQ[GNT_IDX]=0 SHALL cause a transition to RELEASE at the next edge, with GNT=0 in RELEASE.
REQ-016 RELEASE SHALL last one cycle (dead cycle; no overlapping grants); with no qualifying request it SHALL go to IDLE.
REQ-017 EN=0 during GRANT SHALL NOT revoke the grant; it only blocks new grants.
REQ-018 In GRANT, REQ changes on non-holder bits SHALL be ignored until RELEASE.
REQ-019 GNT SHALL never have more than one bit set.
REQ-020 DONE outside GRANT SHALL be ignored.
REQ-021 In GRANT, if DONE=1 and REQ[GNT_IDX]=0 occur together, the block SHALL perform a single release (one RELEASE cycle).

Reset
REQ-022 RST=1 at a clock edge SHALL force IDLE, GNT=0, GNT_IDX=3 (so requester 0 has first priority), BUSY=0, TOUT=0, timeout counter=0.
REQ-023 Reset during GRANT SHALL drop GNT in the same edge, with no RELEASE cycle.

Configuration
REQ-024 With macro ARB_TIMEOUT_EN defined, a counter SHALL count GRANT cycles from 1; when it reaches TIMEOUT_CYCLES without release, the block SHALL force RELEASE at the next edge and pulse TOUT=1 for that RELEASE cycle.
REQ-025 Without ARB_TIMEOUT_EN, no counter SHALL exist, TOUT SHALL be tied 0, and a grant SHALL be held indefinitely.

Structure
REQ-026 Package rr_arbiter_pkg SHALL hold the state encoding typedef (IDLE=0, GRANT=1, RELEASE=2) and constant NUM_REQ=4.
REQ-027 GNT SHALL be generated by a sub-module instance of decoder_2_to_4 (EN=BUSY, A0/A1=GNT_IDX) feeding the GNT register.

Verification
REQ-028 Reset, then REQ=4'b0001 with EN=1 -> the next cycle shows GNT=0001, GNT_IDX=0, BUSY=1.
REQ-029 REQ=4'b1111 held, DONE pulsed after each grant -> grant order 0,1,2,3,0 with one GNT=0 cycle between grants.
REQ-030 Holder 2 granted, then REQ=4'b1001 -> the next grant goes to requester 3, then 0.
REQ-031 EN=0 with REQ=4'b0010 -> GNT stays 0; EN->1 -> GNT=0010 one cycle later; EN->0 mid-grant -> grant held.
REQ-032 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, REQ=0001 held with no DONE -> 4 GRANT cycles, then RELEASE with TOUT=1, then re-grant to 0.
REQ-033 RST asserted in GRANT -> GNT=0000 and GNT_IDX=3 after the edge; REQ=0011 afterwards -> requester 0 granted first.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// ============================================================================
// Module      : rr_arbiter_pkg
// Description : State encoding, requester count and round-robin pick helper
//               for the 4-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // First set request bit searching upward from last+1, wrapping 3->0.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         last);
        logic [1:0] w_idx;
        logic [1:0] w_win;
        logic       w_found;
        w_win   = last;
        w_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = last + i[1:0];
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        return w_win;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4_decoder.sv
// ============================================================================
// Module      : decoder_2_to_4
// Description : Enabled 2-to-4 one-hot decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_2_to_4 (
    input  logic       EN,
    input  logic       A0,
    input  logic       A1,
    output logic [3:0] Y
);

    assign Y = EN ? (4'b0001 << {A1, A0}) : 4'b0000;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module      : rr_arbiter_4
// Description : 4-requester round-robin arbiter with a one-cycle dead RELEASE
//               between grants. Optional grant timeout via macro ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4
    import rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [NUM_REQ-1:0]  REQ,
    input  logic                DONE,
    output logic [NUM_REQ-1:0]  GNT,
    output logic [1:0]          GNT_IDX,
    output logic                BUSY,
    output logic                TOUT
);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_dec;
    logic               w_busy_nxt;
    logic               w_release;
    logic               w_timeout;

    assign w_release = DONE || !REQ[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            GRANT: begin
                if (w_release || w_timeout) begin
                    w_state_nxt = RELEASE;
                end
            end
            default: begin
                if (EN && (|REQ)) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = rr_pick(REQ, r_idx);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == GRANT);

    // Decode the next-state index so the grant register lines up with GNT_IDX.
    decoder_2_to_4 u_dec (
        .EN (w_busy_nxt),
        .A0 (w_idx_nxt[0]),
        .A1 (w_idx_nxt[1]),
        .Y  (w_gnt_dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_idx   <= 2'd3;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gnt   <= w_gnt_dec;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tout;

    // Counter reads 1 in the first GRANT cycle and clears outside GRANT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_tout <= 1'b0;
        end else begin
            if (w_busy_nxt) begin
                r_cnt <= (r_state == GRANT) ? r_cnt + 1'b1 : CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            r_tout <= (r_state == GRANT) && w_timeout && !w_release;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign TOUT      = r_tout;
`else
    assign w_timeout = 1'b0;
    assign TOUT      = 1'b0;
`endif

    assign GNT     = r_gnt;
    assign GNT_IDX = r_idx;
    assign BUSY    = (r_state == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Directed self-checking bench for rr_arbiter_4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GNT_IDX;
    logic       BUSY;
    logic       TOUT;

    int r_total = 0;
    int r_bad   = 0;

    rr_arbiter_4 #(.TIMEOUT_CYCLES(4)) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_IDX (GNT_IDX),
        .BUSY    (BUSY),
        .TOUT    (TOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_total++;
        if (got !== exp) begin
            r_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] g, input logic [1:0] idx, input logic b);
        check({tag, "_gnt"}, {28'd0, GNT}, {28'd0, g});
        check({tag, "_idx"}, {30'd0, GNT_IDX}, {30'd0, idx});
        check({tag, "_busy"}, {31'd0, BUSY}, {31'd0, b});
    endtask

    initial begin
        int exp_idx;
        RST = 1'b1; EN = 1'b0; REQ = 4'b0000; DONE = 1'b0;
        step();
        step();
        check_gnt("reset", 4'b0000, 2'd3, 1'b0);
        check("reset_tout", {31'd0, TOUT}, 32'd0);

        // First grant from reset
        RST = 1'b0; EN = 1'b1; REQ = 4'b0001;
        step();
        check_gnt("first", 4'b0001, 2'd0, 1'b1);
        REQ = 4'b0000; DONE = 1'b1;
        step();
        check_gnt("first_rel", 4'b0000, 2'd0, 1'b0);
        DONE = 1'b0;
        step();
        check_gnt("first_idle", 4'b0000, 2'd0, 1'b0);

        // Full rotation with all requesting
        RST = 1'b1;
        step();
        RST = 1'b0; REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % 4;
            step();
            check_gnt($sformatf("rot%0d", k), 4'b0001 << exp_idx, exp_idx[1:0], 1'b1);
            DONE = 1'b1;
            step();
            check_gnt($sformatf("rot%0d_rel", k), 4'b0000, exp_idx[1:0], 1'b0);
            DONE = 1'b0;
        end

        // Holder 2, then requests 3 and 0
        REQ = 4'b0100;
        step();
        check_gnt("h2", 4'b0100, 2'd2, 1'b1);
        REQ = 4'b1001;
        step();
        check_gnt("h2_drop", 4'b0000, 2'd2, 1'b0);
        step();
        check_gnt("h3", 4'b1000, 2'd3, 1'b1);
        REQ = 4'b1011;
        step();
        check_gnt("h3_ignore", 4'b1000, 2'd3, 1'b1);
        DONE = 1'b1;
        step();
        check_gnt("h3_rel", 4'b0000, 2'd3, 1'b0);
        DONE = 1'b0;
        step();
        check_gnt("h0_wrap", 4'b0001, 2'd0, 1'b1);
        REQ = 4'b0000;
        step();
        step();
        check_gnt("idle_again", 4'b0000, 2'd0, 1'b0);

        // Enable gating; DONE in IDLE has no effect
        EN = 1'b0; REQ = 4'b0010; DONE = 1'b1;
        step();
        check_gnt("en0_a", 4'b0000, 2'd0, 1'b0);
        DONE = 1'b0;
        step();
        check_gnt("en0_b", 4'b0000, 2'd0, 1'b0);
        EN = 1'b1;
        step();
        check_gnt("en1", 4'b0010, 2'd1, 1'b1);
        EN = 1'b0;
        step();
        step();
        check_gnt("en0_hold", 4'b0010, 2'd1, 1'b1);
        DONE = 1'b1;
        step();
        check_gnt("en0_rel", 4'b0000, 2'd1, 1'b0);
        DONE = 1'b0;
        step();
        check_gnt("en0_idle", 4'b0000, 2'd1, 1'b0);

        // Long hold: timeout after 4 GRANT cycles when enabled
        EN = 1'b1; REQ = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            step();
            check_gnt($sformatf("hold%0d", c), 4'b0001, 2'd0, 1'b1);
            check($sformatf("hold%0d_tout", c), {31'd0, TOUT}, 32'd0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check_gnt("tmo", 4'b0000, 2'd0, 1'b0);
        check("tmo_tout", {31'd0, TOUT}, 32'd1);
`else
        check_gnt("tmo", 4'b0001, 2'd0, 1'b1);
        check("tmo_tout", {31'd0, TOUT}, 32'd0);
`endif
        step();
        check_gnt("tmo_regrant", 4'b0001, 2'd0, 1'b1);
        check("tmo_regrant_tout", {31'd0, TOUT}, 32'd0);

        // Reset while granted
        RST = 1'b1;
        step();
        check_gnt("rst_grant", 4'b0000, 2'd3, 1'b0);
        check("rst_tout", {31'd0, TOUT}, 32'd0);
        RST = 1'b0; REQ = 4'b0011;
        step();
        check_gnt("rst_first", 4'b0001, 2'd0, 1'b1);

        // DONE and holder drop together: one RELEASE cycle only
        REQ = 4'b0010; DONE = 1'b1;
        step();
        check_gnt("both_rel", 4'b0000, 2'd0, 1'b0);
        DONE = 1'b0;
        step();
        check_gnt("both_next", 4'b0010, 2'd1, 1'b1);

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

    // GNT must be one-hot or zero at all times
    always @(negedge CLK) begin
        if (RST === 1'b0 && !$onehot0(GNT)) begin
            check("onehot", {28'd0, GNT}, 32'd0);
        end
    end

endmodule

`default_nettype wire
